// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the rate-1/2, K=3 (7,5) hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 1 << (K - 1);
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    typedef logic [1:0] state_t;

    // Encoder output for input b leaving state s={b1,b2}: {g7 bit, g5 bit}.
    function automatic logic [1:0] branch_out(state_t s, logic b);
        logic [2:0] r;
        r = {b, s};
        return {^(r & G0), ^(r & G1)};
    endfunction

    function automatic logic [1:0] hamming2(logic [1:0] a, logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

endpackage

// File: rtl/viterbi_decoder_k3_acs.sv
// Add-compare-select for one trellis state; ties resolve to predecessor a (b2=0).
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [1:0]      bm_a,
    input  logic [1:0]      bm_b,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);

    function automatic logic [PM_W-1:0] sat_add(logic [PM_W-1:0] pm, logic [1:0] bm);
        logic [PM_W:0] s;
        s = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
        return s[PM_W] ? {PM_W{1'b1}} : s[PM_W-1:0];
    endfunction

    logic [PM_W-1:0] cand_a;
    logic [PM_W-1:0] cand_b;

    always_comb begin
        cand_a = sat_add(pm_a, bm_a);
        cand_b = sat_add(pm_b, bm_b);
        dec_o  = (cand_b < cand_a);
        pm_o   = dec_o ? cand_b : cand_a;
    end

endmodule

// File: rtl/viterbi_decoder_k3.sv
// Register-exchange hard-decision Viterbi decoder, K=3, generators 7/5.
// Define VITERBI_ERR_CNT_EN to build the channel bit-error estimator on err_cnt.
module viterbi_decoder_k3
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  d_in,
    output logic        d_out,
    output logic        valid_o,
    output logic [15:0] err_cnt
);

    localparam int FILL_W = $clog2(TB_DEPTH + 1);

    logic [PM_W-1:0]     pm_q     [NUM_STATES];
    logic [PM_W-1:0]     pm_d     [NUM_STATES];
    logic [PM_W-1:0]     acs_pm   [NUM_STATES];
    logic [1:0]          bm_a     [NUM_STATES];
    logic [1:0]          bm_b     [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_q   [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_d   [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_new [NUM_STATES];
    logic [NUM_STATES-1:0] dec;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                d_out_q, d_out_d;
    logic                valid_q, valid_d;
    logic [PM_W-1:0]     m;
    state_t              best;

    // Next state {b,b1} is reached from {b1,0} (a) or {b1,1} (b) on input b.
    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        localparam state_t NS   = state_t'(g);
        localparam logic   B_IN = NS[1];
        localparam state_t PA   = {NS[0], 1'b0};
        localparam state_t PB   = {NS[0], 1'b1};

        assign bm_a[g] = hamming2(branch_out(PA, B_IN), d_in);
        assign bm_b[g] = hamming2(branch_out(PB, B_IN), d_in);

        viterbi_acs #(.PM_W(PM_W)) u_acs (
            .pm_a  (pm_q[PA]),
            .pm_b  (pm_q[PB]),
            .bm_a  (bm_a[g]),
            .bm_b  (bm_b[g]),
            .pm_o  (acs_pm[g]),
            .dec_o (dec[g])
        );
    end

    always_comb begin
        state_t ns;
        state_t pred;
        m    = acs_pm[0];
        best = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            ns          = state_t'(i);
            pred        = {ns[0], dec[i]};
            surv_new[i] = {surv_q[pred][TB_DEPTH-2:0], ns[1]};
            if (acs_pm[i] < m) begin
                m    = acs_pm[i];
                best = state_t'(i);
            end
        end
    end

    always_comb begin
        pm_d    = pm_q;
        surv_d  = surv_q;
        fill_d  = fill_q;
        d_out_d = d_out_q;
        valid_d = 1'b0;
        if (enable) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_d[i] = acs_pm[i] - m;
            end
            surv_d  = surv_new;
            fill_d  = (fill_q == FILL_W'(TB_DEPTH)) ? fill_q : fill_q + FILL_W'(1);
            valid_d = (fill_q >= FILL_W'(TB_DEPTH - 1));
            d_out_d = surv_new[best][TB_DEPTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : {PM_W{1'b1}};
                surv_q[i] <= '0;
            end
            fill_q  <= '0;
            d_out_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pm_q    <= pm_d;
            surv_q  <= surv_d;
            fill_q  <= fill_d;
            d_out_q <= d_out_d;
            valid_q <= valid_d;
        end
    end

    assign d_out   = d_out_q;
    assign valid_o = valid_q;

`ifdef VITERBI_ERR_CNT_EN
    // Running sum of normalisation amounts equals the best path's accumulated errors.
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + 17'(m);
        err_cnt_d = err_cnt_q;
        if (enable) begin
            err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Bench for viterbi_decoder_k3: random data through a (7,5) encoder, checked against the sent bits.
module tb_viterbi_decoder_k3;

    localparam int TB_DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  d_in = 2'b00;
    logic        d_out;
    logic        valid_o;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    viterbi_decoder_k3 #(.TB_DEPTH(TB_DEPTH), .PM_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .d_in    (d_in),
        .d_out   (d_out),
        .valid_o (valid_o),
        .err_cnt (err_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int ncyc, input string tag);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rst    = 1'b0;
            enable = 1'b1;
            d_in   = 2'b11;
            @(posedge clk);
            #1;
            check_val({tag, "_rst_dout"},  32'(d_out),   32'd0);
            check_val({tag, "_rst_valid"}, 32'(valid_o), 32'd0);
            check_val({tag, "_rst_err"},   32'(err_cnt), 32'd0);
        end
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
    endtask

    // Encodes nbits data bits from state 0 with optional channel errors and enable gaps.
    task automatic run_stream(input int nbits, input bit zero_data, input bit burst,
                              input int hit_idx, input bit gaps, input string tag);
        bit          data[$];
        bit          gap_pat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        b, b1, b2, en, exp_bit;
        logic [1:0]  sym;
        int          n_sym, n_en, cyc, errs, exp_err;
        b1 = 1'b0; b2 = 1'b0;
        n_sym = 0; n_en = 0; cyc = 0; errs = 0;
        while (n_sym < nbits) begin
            en = gaps ? gap_pat[cyc % 6] : 1'b1;
            @(negedge clk);
            if (en) begin
                b = zero_data ? 1'b0 : 1'($urandom);
                data.push_back(b);
                sym = {b ^ b1 ^ b2, b ^ b2};
                if (burst && n_sym < 256 && (n_sym % 16 == 14 || n_sym % 16 == 15)) begin
                    sym[1] = ~sym[1];
                    errs++;
                end
                if (n_sym == hit_idx) begin
                    sym  = sym ^ 2'b11;
                    errs += 2;
                end
                b2 = b1;
                b1 = b;
                enable = 1'b1;
                d_in   = sym;
                n_sym++;
                n_en++;
            end else begin
                enable = 1'b0;
                d_in   = 2'($urandom);
            end
            @(posedge clk);
            #1;
            exp_bit = (n_en >= TB_DEPTH) ? data[n_en - TB_DEPTH] : 1'b0;
            if (en) begin
                check_val({tag, "_valid"}, 32'(valid_o), (n_en >= TB_DEPTH) ? 32'd1 : 32'd0);
                check_val({tag, "_dout"},  32'(d_out),   32'(exp_bit));
            end else begin
                check_val({tag, "_gap_valid"}, 32'(valid_o), 32'd0);
                check_val({tag, "_gap_dout"},  32'(d_out),   32'(exp_bit));
            end
            if (errs == 0) begin
                check_val({tag, "_err_clean"}, 32'(err_cnt), 32'd0);
            end
            cyc++;
        end
`ifdef VITERBI_ERR_CNT_EN
        exp_err = errs;
`else
        exp_err = 0;
`endif
        check_val({tag, "_err_final"}, 32'(err_cnt), 32'(exp_err));
        @(negedge clk);
        enable = 1'b0;
    endtask

    initial begin
        do_reset(3, "reset");
        run_stream(256, 1'b0, 1'b0, -1, 1'b0, "clean");

        do_reset(1, "pre_burst");
        run_stream(288, 1'b0, 1'b1, -1, 1'b0, "burst");

        do_reset(1, "pre_hit");
        run_stream(80, 1'b1, 1'b0, 20, 1'b0, "hit");

        do_reset(1, "pre_gaps");
        run_stream(256, 1'b0, 1'b0, -1, 1'b1, "gaps");

        do_reset(1, "pre_mid");
        run_stream(40, 1'b0, 1'b0, -1, 1'b0, "mid_a");
        do_reset(1, "mid");
        run_stream(120, 1'b0, 1'b0, -1, 1'b0, "mid_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
